add_sched: RTL and testbench
============================

# add_sched

Round-robin scheduler that shares one `ebit` 8-bit adder instance between NREQ requesters. Each requester presents an operand pair with a request. The scheduler grants one requester at a time, captures its operands, and drives the shared adder. It returns a registered sum, carry flag and requester ID. It sits between the requesting blocks and the single adder datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 8: operand width; fixed by `ebit`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: per-requester request, level.
- `a_in` in NREQ*W: operand A; requester i uses bits [i*W +: W].
- `b_in` in NREQ*W: operand B, same packing as `a_in`.
- `gnt` out NREQ: one-hot grant pulse, registered.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out W: sum, wrapped or saturated.
- `res_carry` out 1: carry out of the W-bit add.
- `res_id` out $clog2(NREQ): index of the requester owning the result.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - BUSY: adder evaluating captured operands.
- IDLE with any `req` bit high: the winner is the first set bit, searching upward from `ptr+1` and wrapping modulo NREQ. At the next edge:
  - `gnt <= onehot(winner)`.
  - `a_q <= a_in[winner]`, `b_q <= b_in[winner]`, `id_q <= winner`.
  - `ptr <= winner`.
  - State goes to BUSY.
- IDLE with no `req`: stay in IDLE, `gnt = 0`.
- BUSY: `ebit` computes `a_q+b_q` combinationally. At the next edge:
  - `res_data`, `res_carry`, `res_id <= id_q` and `res_valid <= 1` are registered.
  - `gnt <= 0`.
  - State returns to IDLE.
- `req` is ignored while in BUSY.
- `res_carry = (sum < a_q)`, computed in the scheduler because `ebit` has no carry port.
- Requester protocol:
  - Operands stay stable while `req` is high and until `gnt` is seen.
  - The requester deasserts `req` on the edge at which it samples `gnt`. Keeping `req` high requests another operation.
- Reset values: state IDLE, `ptr = NREQ-1` (requester 0 has first priority), `gnt = 0`, `res_valid = 0`, `res_data = 0`, `res_carry = 0`, `res_id = 0`, `a_q = 0`, `b_q = 0`, `id_q = 0`.
- Reset asserted mid-operation (in BUSY) drops the in-flight operation: no `res_valid`, all registers return to reset values.
- There is no backpressure on the result. `res_data`, `res_carry` and `res_id` hold until the next result.

## Timing
- Cycle N: IDLE with `req[i]` high and i winning.
- Cycle N+1: `gnt[i] = 1`, state BUSY.
- Cycle N+2: `res_valid = 1`, `res_id = i`, state IDLE; a new grant can be decided in this cycle.
- Request-to-result latency is 2 cycles. Maximum throughput is one operation per 2 cycles.
- A single requester holding `req` is re-granted every 2 cycles unless other requesters are waiting. With others waiting, rotation is strict.
- `gnt` and `res_valid` never both assert for the same operation in the same cycle.

## Configuration
- `ADD_SAT_EN` defined: when `res_carry` is 1, `res_data` is forced to all ones (0xFF); otherwise it is the sum. `res_carry` is still reported.
- `ADD_SAT_EN` undefined: `res_data` is the wrapped W-bit sum from `ebit`.

## Structure
- Package `add_pkg`:
  - Constants `NREQ_DEF`, `W_DEF`, `IDW`.
  - State typedef `sched_state_t` {IDLE, BUSY}.
- Sub-module `rr_pick`: combinational round-robin selector taking `req` and `ptr` and producing `winner` and `any`.
- `add_sched` holds the FSM, the operand, pointer and result registers, and one `ebit` instance.

## Test plan
- Single request: `req[0]` with a=0x54, b=0x54 → `gnt[0]` in cycle N+1; in N+2 `res_data=0xA8`, `res_carry=0`, `res_id=0`.
- All four requests after reset, each held until granted → grants in order 0,1,2,3, spaced 2 cycles apart; four `res_valid` pulses with matching `res_id`.
- `req[0]` and `req[2]` both held continuously → grants alternate 0,2,0,2; `req[1]` and `req[3]` are never granted.
- a=0x54, b=0xFF → `res_carry=1`; `res_data=0x53` without `ADD_SAT_EN`, 0xFF with it.
- a=0x54, b=0x7F → `res_data=0xD3`, `res_carry=0` in both builds.
- `rst` asserted during BUSY → no `res_valid`, `gnt=0`; the next single request to `req[3]` is granted after 1 cycle, then `req[0]` beats `req[1]` when both are raised.

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants and FSM state type for the round-robin adder scheduler.
package add_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int IDW      = $clog2(NREQ_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

endpackage

// File: rtl/add_sched_rr_pick.sv
// Combinational round-robin selector: first set request above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] winner_o,
  output logic            any_o
);

  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_l;
    any_o    = 1'b0;
    winner_o = '0;
    idx      = 0;
    idx_l    = '0;
    // Walk from the farthest offset down so the nearest set bit is written last.
    for (int k = NREQ; k >= 1; k--) begin
      idx   = (int'(ptr_i) + k) % NREQ;
      idx_l = ID_W'(idx);
      if (req_i[idx_l]) begin
        winner_o = idx_l;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ebit.sv
// Shared 8-bit wrapping adder datapath; carry is not exported.
module ebit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one ebit adder among NREQ requesters.
// Optional build macro ADD_SAT_EN saturates res_data_o to all ones on carry.
//   state | meaning
//   IDLE  | arbitrate among pending requests
//   BUSY  | adder evaluating captured operands
module add_sched
  import add_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NREQ-1:0]                    req_i,
  input  logic [NREQ*W-1:0]                  a_i,
  input  logic [NREQ*W-1:0]                  b_i,
  output logic [NREQ-1:0]                    gnt_o,
  output logic                               res_valid_o,
  output logic [W-1:0]                       res_data_o,
  output logic                               res_carry_o,
  output logic [$clog2(NREQ)-1:0]            res_id_o
);

  localparam int ID_W = $clog2(NREQ);

  sched_state_t    state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [NREQ-1:0] gnt_q;
  logic            res_valid_q;
  logic [W-1:0]    res_data_q;
  logic            res_carry_q;
  logic [ID_W-1:0] res_id_q;

  logic [ID_W-1:0] winner_w;
  logic            any_w;
  logic [W-1:0]    sum_w;
  logic            carry_d;
  logic [W-1:0]    data_d;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (winner_w),
    .any_o    (any_w)
  );

  ebit u_ebit (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum_w)
  );

  // The adder wraps, so a result below an operand means the add overflowed.
  assign carry_d = (sum_w < a_q);

`ifdef ADD_SAT_EN
  assign data_d = carry_d ? '1 : sum_w;
`else
  assign data_d = sum_w;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= '0;
    end else begin
      res_valid_q <= 1'b0;
      gnt_q       <= '0;
      case (state_q)
        IDLE: begin
          if (any_w) begin
            gnt_q   <= NREQ'(1) << winner_w;
            a_q     <= a_i[int'(winner_w)*W +: W];
            b_q     <= b_i[int'(winner_w)*W +: W];
            id_q    <= winner_w;
            ptr_q   <= winner_w;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          res_valid_q <= 1'b1;
          res_data_q  <= data_d;
          res_carry_q <= carry_d;
          res_id_q    <= id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_carry_o = res_carry_q;
  assign res_id_o    = res_id_q;

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched with hand-computed expectations.
module tb_add_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0] gnt;
  logic            res_valid;
  logic [W-1:0]    res_data;
  logic            res_carry;
  logic [1:0]      res_id;

  int n_cmp = 0;
  int n_err = 0;

  add_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .a_i         (a_in),
    .b_i         (b_in),
    .gnt_o       (gnt),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .res_carry_o (res_carry),
    .res_id_o    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  logic [7:0] exp_sum [4];
  logic [7:0] sat_ff;

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
`ifdef ADD_SAT_EN
    sat_ff = 8'hFF;
`else
    sat_ff = 8'h53;
`endif
    step(); step();
    check("rst_gnt",   32'(gnt), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_data",  32'(res_data), 0);
    check("rst_carry", 32'(res_carry), 0);
    check("rst_id",    32'(res_id), 0);
    rst = 1'b0;

    // Single request on requester 0
    set_ops(0, 8'h54, 8'h54);
    req = 4'b0001;
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_novalid", 32'(res_valid), 0);
    req = 4'b0000;
    step();
    check("single_valid", 32'(res_valid), 1);
    check("single_data",  32'(res_data), 32'hA8);
    check("single_carry", 32'(res_carry), 0);
    check("single_id",    32'(res_id), 0);
    check("single_gnt_off", 32'(gnt), 0);
    step();
    check("single_pulse", 32'(res_valid), 0);
    check("single_hold",  32'(res_data), 32'hA8);

    // All four requesters after reset: strict order 0,1,2,3
    rst = 1'b1; step(); rst = 1'b0;
    set_ops(0, 8'h01, 8'h02); exp_sum[0] = 8'h03;
    set_ops(1, 8'h10, 8'h20); exp_sum[1] = 8'h30;
    set_ops(2, 8'h40, 8'h41); exp_sum[2] = 8'h81;
    set_ops(3, 8'h7F, 8'h7F); exp_sum[3] = 8'hFE;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("all_gnt%0d", i), 32'(gnt), 32'(1 << i));
      check($sformatf("all_novalid%0d", i), 32'(res_valid), 0);
      req[i] = 1'b0;
      step();
      check($sformatf("all_valid%0d", i), 32'(res_valid), 1);
      check($sformatf("all_id%0d", i), 32'(res_id), 32'(i));
      check($sformatf("all_data%0d", i), 32'(res_data), 32'(exp_sum[i]));
      check($sformatf("all_gnt_off%0d", i), 32'(gnt), 0);
    end

    // Requesters 0 and 2 held: alternate 0,2,0,2
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("alt_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
      step();
      check($sformatf("alt_valid%0d", i), 32'(res_valid), 1);
      check($sformatf("alt_id%0d", i), 32'(res_id), (i % 2 == 0) ? 32'd0 : 32'd2);
    end
    req = 4'b0000;
    step();

    // Carry case
    set_ops(1, 8'h54, 8'hFF);
    req = 4'b0010;
    step();
    check("carry_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    check("carry_valid", 32'(res_valid), 1);
    check("carry_flag",  32'(res_carry), 1);
    check("carry_data",  32'(res_data), 32'(sat_ff));
    check("carry_id",    32'(res_id), 1);

    // No-carry near the top of range
    set_ops(1, 8'h54, 8'h7F);
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("nc_valid", 32'(res_valid), 1);
    check("nc_data",  32'(res_data), 32'hD3);
    check("nc_carry", 32'(res_carry), 0);

    // Reset while BUSY drops the operation
    set_ops(1, 8'h11, 8'h22);
    req = 4'b0010;
    step();
    check("rb_gnt", 32'(gnt), 32'h2);
    rst = 1'b1;
    req = 4'b0000;
    step();
    check("rb_gnt_clr",   32'(gnt), 0);
    check("rb_novalid",   32'(res_valid), 0);
    check("rb_data_clr",  32'(res_data), 0);
    rst = 1'b0;
    step();
    check("rb_novalid2",  32'(res_valid), 0);
    set_ops(3, 8'h05, 8'h06);
    req = 4'b1000;
    step();
    check("rb_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    check("rb_valid3", 32'(res_valid), 1);
    check("rb_id3",    32'(res_id), 3);
    check("rb_data3",  32'(res_data), 32'h0B);
    req = 4'b0011;
    step();
    check("rb_gnt0_first", 32'(gnt), 32'h1);
    req = 4'b0010;
    step();
    check("rb_id0", 32'(res_id), 0);
    step();
    check("rb_gnt1_next", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
